// File: rtl/admm_residual_checker_if.sv
// Shared read bus between the ADMM residual checker and its three RAMs
// (solver variable v, slack z, previous slack z_prev).
//   rd_addr        : shared pipelined read address
//   rd_en          : read strobe
//   v_rd_data      : v word, valid RD_LATENCY cycles after its address
//   z_rd_data      : z word, same timing
//   z_prev_rd_data : z_prev word, same timing
// master = checker side, slave = RAM side.
interface admm_residual_checker_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] v_rd_data;
  logic [DATA_WIDTH-1:0] z_rd_data;
  logic [DATA_WIDTH-1:0] z_prev_rd_data;

  modport master (
    output rd_addr,
    output rd_en,
    input  v_rd_data,
    input  z_rd_data,
    input  z_prev_rd_data
  );

  modport slave (
    input  rd_addr,
    input  rd_en,
    output v_rd_data,
    output z_rd_data,
    output z_prev_rd_data
  );
endinterface

// File: rtl/admm_residual_checker.sv
// ADMM convergence checker. One pass streams every input and state element
// of v, z and z_prev, computes the primal residuals max|v-z| (input and
// state segments separately) and the scaled dual residual rho*max|z-z_prev|,
// then reports convergence / iteration-limit status to the sequencer.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start, clear_iter   : pass trigger pulse, iteration counter clear
//   active_horizon      : horizon for this pass (clamped to 1..HORIZON)
//   rho, pri_tol, dual_tol, max_iter : pass settings (sampled on start,
//                         max_iter read at decision time)
//   rd_bus              : shared RAM read bus (master side)
//   pri_res_u, pri_res_x, dual_res   : residual results
//   converged, max_iter_hit, iter_count, busy, done : status
module admm_residual_checker #(
  parameter int STATE_DIM  = 6,
  parameter int INPUT_DIM  = 3,
  parameter int HORIZON    = 30,
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int ADDR_WIDTH = 9,
  parameter int RD_LATENCY = 2,
  parameter int ITER_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  clear_iter,
  input  logic [15:0]           active_horizon,
  input  logic [DATA_WIDTH-1:0] rho,
  input  logic [DATA_WIDTH-1:0] pri_tol,
  input  logic [DATA_WIDTH-1:0] dual_tol,
  input  logic [ITER_WIDTH-1:0] max_iter,
  admm_residual_checker_if.master rd_bus,
  output logic [DATA_WIDTH-1:0] pri_res_u,
  output logic [DATA_WIDTH-1:0] pri_res_x,
  output logic [DATA_WIDTH-1:0] dual_res,
  output logic                  converged,
  output logic                  max_iter_hit,
  output logic [ITER_WIDTH-1:0] iter_count,
  output logic                  busy,
  output logic                  done
);

  localparam int STATE_BASE = (HORIZON - 1) * INPUT_DIM;
  localparam logic [ADDR_WIDTH-1:0] STATE_BASE_A = ADDR_WIDTH'(STATE_BASE);
  localparam logic [15:0] HORIZON_H = 16'(HORIZON);
  localparam logic [15:0] IN_DIM_H  = 16'(INPUT_DIM);
  localparam logic [15:0] ST_DIM_H  = 16'(STATE_DIM);
  localparam logic [DATA_WIDTH-1:0] MAG_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [ITER_WIDTH-1:0] ITER_ONE = {{(ITER_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_DRAIN  = 3'd2,
    S_SCALE  = 3'd3,
    S_DECIDE = 3'd4
  } state_t;

  state_t                  state_r;
  logic [ADDR_WIDTH-1:0]   rd_addr_r;
  logic                    rd_en_r;
  logic                    seg_r;        // segment of the address on the bus: 0 input, 1 state
  logic [15:0]             left_r;       // addresses left in current segment, including current
  logic [15:0]             x_cnt_r;
  logic [DATA_WIDTH-1:0]   rho_r;
  logic [DATA_WIDTH-1:0]   pri_tol_r;
  logic [DATA_WIDTH-1:0]   dual_tol_r;

  // Read-return tracking and one registered magnitude stage
  logic [RD_LATENCY-1:0]   vsr_r;
  logic [RD_LATENCY-1:0]   tsr_r;
  logic                    stg_vld_r;
  logic                    stg_seg_r;
  logic [DATA_WIDTH-1:0]   stg_dvz_r;
  logic [DATA_WIDTH-1:0]   stg_dz_r;
  logic [DATA_WIDTH-1:0]   u_max_r;
  logic [DATA_WIDTH-1:0]   x_max_r;
  logic [DATA_WIDTH-1:0]   dz_max_r;

  logic [15:0]             h_s;
  logic [15:0]             u_cnt_s;
  logic [15:0]             x_cnt_s;
  logic                    take_start_s;
  logic [2*DATA_WIDTH-1:0] scaled_s;
  logic [DATA_WIDTH-1:0]   dual_sat_s;
  logic                    conv_s;
  logic [ITER_WIDTH-1:0]   iter_next_s;
  logic                    hit_s;

  // |a - b| evaluated one bit wider than the data, saturated to the largest positive word
  function automatic logic [DATA_WIDTH-1:0] sat_abs_diff(input logic [DATA_WIDTH-1:0] a,
                                                         input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH:0] d;
    logic [DATA_WIDTH:0] m;
    d = {a[DATA_WIDTH-1], a} - {b[DATA_WIDTH-1], b};
    if (d[DATA_WIDTH]) begin
      m = (~d) + {{DATA_WIDTH{1'b0}}, 1'b1};
    end else begin
      m = d;
    end
    if (m > {1'b0, MAG_MAX}) begin
      return MAG_MAX;
    end else begin
      return m[DATA_WIDTH-1:0];
    end
  endfunction

  assign rd_bus.rd_addr = rd_addr_r;
  assign rd_bus.rd_en   = rd_en_r;

  // Horizon clamp, segment sizes and the end-of-pass decision terms
  always_comb begin
    if (active_horizon == 16'd0) begin
      h_s = 16'd1;
    end else if (active_horizon > HORIZON_H) begin
      h_s = HORIZON_H;
    end else begin
      h_s = active_horizon;
    end
    u_cnt_s      = (h_s - 16'd1) * IN_DIM_H;
    x_cnt_s      = h_s * ST_DIM_H;
    take_start_s = (state_r == S_IDLE) && start;

    scaled_s = ({{DATA_WIDTH{1'b0}}, rho_r} * {{DATA_WIDTH{1'b0}}, dz_max_r}) >> FRAC_BITS;
    if (scaled_s > {{DATA_WIDTH{1'b0}}, MAG_MAX}) begin
      dual_sat_s = MAG_MAX;
    end else begin
      dual_sat_s = scaled_s[DATA_WIDTH-1:0];
    end
    conv_s = (u_max_r <= pri_tol_r) && (x_max_r <= pri_tol_r) && (dual_sat_s <= dual_tol_r);
    if (iter_count == {ITER_WIDTH{1'b1}}) begin
      iter_next_s = iter_count;
    end else begin
      iter_next_s = iter_count + ITER_ONE;
    end
    hit_s = !conv_s && (iter_next_s >= max_iter);
  end

  // Read-return pipeline: tag shift register, magnitude stage, running maxima
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsr_r     <= {RD_LATENCY{1'b0}};
      tsr_r     <= {RD_LATENCY{1'b0}};
      stg_vld_r <= 1'b0;
      stg_seg_r <= 1'b0;
      stg_dvz_r <= {DATA_WIDTH{1'b0}};
      stg_dz_r  <= {DATA_WIDTH{1'b0}};
      u_max_r   <= {DATA_WIDTH{1'b0}};
      x_max_r   <= {DATA_WIDTH{1'b0}};
      dz_max_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      vsr_r[0] <= rd_en_r;
      tsr_r[0] <= seg_r;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vsr_r[i] <= vsr_r[i-1];
        tsr_r[i] <= tsr_r[i-1];
      end
      stg_vld_r <= vsr_r[RD_LATENCY-1];
      stg_seg_r <= tsr_r[RD_LATENCY-1];
      stg_dvz_r <= sat_abs_diff(rd_bus.v_rd_data, rd_bus.z_rd_data);
      stg_dz_r  <= sat_abs_diff(rd_bus.z_rd_data, rd_bus.z_prev_rd_data);
      if (take_start_s) begin
        u_max_r  <= {DATA_WIDTH{1'b0}};
        x_max_r  <= {DATA_WIDTH{1'b0}};
        dz_max_r <= {DATA_WIDTH{1'b0}};
      end else if (stg_vld_r) begin
        if (!stg_seg_r && (stg_dvz_r > u_max_r)) begin
          u_max_r <= stg_dvz_r;
        end
        if (stg_seg_r && (stg_dvz_r > x_max_r)) begin
          x_max_r <= stg_dvz_r;
        end
        if (stg_dz_r > dz_max_r) begin
          dz_max_r <= stg_dz_r;
        end
      end
    end
  end

  // Pass sequencer with address generation and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_IDLE;
      rd_addr_r    <= {ADDR_WIDTH{1'b0}};
      rd_en_r      <= 1'b0;
      seg_r        <= 1'b0;
      left_r       <= 16'd0;
      x_cnt_r      <= 16'd0;
      rho_r        <= {DATA_WIDTH{1'b0}};
      pri_tol_r    <= {DATA_WIDTH{1'b0}};
      dual_tol_r   <= {DATA_WIDTH{1'b0}};
      pri_res_u    <= {DATA_WIDTH{1'b0}};
      pri_res_x    <= {DATA_WIDTH{1'b0}};
      dual_res     <= {DATA_WIDTH{1'b0}};
      converged    <= 1'b0;
      max_iter_hit <= 1'b0;
      iter_count   <= {ITER_WIDTH{1'b0}};
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done <= 1'b0;
          // Clear lands before the increment of a pass started in the same cycle
          if (clear_iter) begin
            iter_count <= {ITER_WIDTH{1'b0}};
          end
          if (start) begin
            rho_r      <= rho;
            pri_tol_r  <= pri_tol;
            dual_tol_r <= dual_tol;
            x_cnt_r    <= x_cnt_s;
            busy       <= 1'b1;
            rd_en_r    <= 1'b1;
            state_r    <= S_ISSUE;
            // H = 1 has no input elements, so the pass opens on the state segment
            if (h_s == 16'd1) begin
              seg_r     <= 1'b1;
              rd_addr_r <= STATE_BASE_A;
              left_r    <= x_cnt_s;
            end else begin
              seg_r     <= 1'b0;
              rd_addr_r <= {ADDR_WIDTH{1'b0}};
              left_r    <= u_cnt_s;
            end
          end
        end
        S_ISSUE: begin
          if (left_r > 16'd1) begin
            rd_addr_r <= rd_addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            left_r    <= left_r - 16'd1;
          end else if (!seg_r) begin
            seg_r     <= 1'b1;
            rd_addr_r <= STATE_BASE_A;
            left_r    <= x_cnt_r;
          end else begin
            rd_en_r <= 1'b0;
            state_r <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // The last word may still sit in the magnitude stage; it folds into
          // the maxima on this same edge, so only the tag register is watched.
          if (vsr_r == {RD_LATENCY{1'b0}}) begin
            state_r <= S_SCALE;
          end
        end
        S_SCALE: begin
          pri_res_u    <= u_max_r;
          pri_res_x    <= x_max_r;
          dual_res     <= dual_sat_s;
          converged    <= conv_s;
          iter_count   <= iter_next_s;
          max_iter_hit <= hit_s;
          done         <= 1'b1;
          state_r      <= S_DECIDE;
        end
        S_DECIDE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          rd_en_r <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/admm_residual_checker.md
Name: admm_residual_checker

Overview:
Next-generation ADMM convergence checker. Streams the solver variable (v), the slack (z) and the previous slack (z_prev) from three RAMs over one shared pipelined read address. Computes per-segment primal residuals max|v - z| for inputs and states, and the scaled dual residual rho*max|z - z_prev|, all in signed fixed point. Tracks the iteration count and reports convergence or iteration-limit termination to the ADMM sequencer.

Parameters:
STATE_DIM, 6, state vector length nx
INPUT_DIM, 3, input vector length nu
HORIZON, 30, maximum horizon N
DATA_WIDTH, 32, signed two's-complement data width
FRAC_BITS, 16, fractional bits of all data, rho and tolerances
ADDR_WIDTH, 9, RAM address width
RD_LATENCY, 2, cycles from rd_addr to valid read data (1..4)
ITER_WIDTH, 16, iteration counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  begin one residual pass (single-cycle pulse)
clear_iter  in  1  zero iter_count (takes effect when not busy)
active_horizon  in  16  horizon length used this pass
rho  in  DATA_WIDTH  ADMM penalty, unsigned Q(FRAC_BITS)
pri_tol  in  DATA_WIDTH  primal tolerance, unsigned
dual_tol  in  DATA_WIDTH  dual tolerance, unsigned
max_iter  in  ITER_WIDTH  iteration limit
rd_addr  out  ADDR_WIDTH  shared read address to the v, z and z_prev RAMs
rd_en  out  1  read strobe
v_rd_data  in  DATA_WIDTH  solver variable word
z_rd_data  in  DATA_WIDTH  slack word
z_prev_rd_data  in  DATA_WIDTH  previous slack word
pri_res_u  out  DATA_WIDTH  max|v - z| over the input segment
pri_res_x  out  DATA_WIDTH  max|v - z| over the state segment
dual_res  out  DATA_WIDTH  rho*max|z - z_prev| over both segments
converged  out  1  all three residuals <= their tolerances
max_iter_hit  out  1  iter_count reached max_iter without convergence
iter_count  out  ITER_WIDTH  completed passes since reset/clear
busy  out  1  pass in progress
done  out  1  one-cycle pulse when results are valid

Behaviour:
- Reset: every output = 0; FSM = IDLE; valid pipeline cleared. Reset mid-pass aborts with no done.
- H = active_horizon clamped to [1, HORIZON]; 0 is treated as 1.
- Memory map: input element (k,i) at k*INPUT_DIM+i, k < H-1. State element (k,j) at STATE_BASE + k*STATE_DIM + j, k < H, with STATE_BASE = (HORIZON-1)*INPUT_DIM.
- FSM: IDLE -> ISSUE -> DRAIN -> SCALE -> DECIDE -> IDLE.
- IDLE: busy=0. start samples H, rho and both tolerances, clears the running maxima, sets busy=1, and moves to ISSUE.
- ISSUE: one address per cycle with rd_en=1; all input addresses first, then all state addresses. If H=1 the input segment is empty and ISSUE begins with the state segment. Each issue pushes a segment tag into a RD_LATENCY-deep valid shift register.
- Datapath: when a tagged word returns, compute the differences at DATA_WIDTH+1 bits and take their absolute values.
  - Saturate each magnitude to 2^(DATA_WIDTH-1)-1.
  - Update the segment maximum (u or x) with |v - z|.
  - Update a single dual maximum with |z - z_prev|.
  - Comparisons are unsigned on magnitudes.
- DRAIN: rd_en=0; wait until the valid shift register is empty.
- SCALE (1 cycle): dual_res = (rho * dz_max) >> FRAC_BITS on a 2*DATA_WIDTH product; saturate to 2^(DATA_WIDTH-1)-1.
- DECIDE (1 cycle):
  - Register pri_res_u, pri_res_x and dual_res.
  - converged = pri_res_u<=pri_tol && pri_res_x<=pri_tol && dual_res<=dual_tol.
  - iter_count increments, saturating at all-ones.
  - max_iter_hit = !converged && (new iter_count >= max_iter).
  - done=1 for exactly this cycle, then return to IDLE with busy=0.
- Results hold until the next DECIDE.
- Latency from start to done = E + RD_LATENCY + 3 cycles, where E = (H-1)*INPUT_DIM + H*STATE_DIM.
- start while busy is ignored. clear_iter while busy is ignored. clear_iter and start in the same IDLE cycle: clear first, then start.
- max_iter = 0: max_iter_hit=1 on every non-converged pass.

Test Plan:
- H=2, all RAMs zero, tolerances 0 -> all residuals 0, converged=1, done exactly 3+12+RD_LATENCY+3 cycles after start, iter_count=1.
- H=3, v[4]=0x0003_0000, z all 0, pri_tol=0x0002_0000 -> pri_res_u=0x0003_0000, pri_res_x=0, converged=0.
- H=2, z[STATE_BASE+1]=0xFFFF_0000 (-1.0), z_prev=0x0001_0000, rho=0x0000_8000 -> dual_res=0x0001_0000.
- Saturation: v=0x7FFF_FFFF, z=0x8000_0000 -> pri_res = 0x7FFF_FFFF; rho=0x0010_0000 with a large dz -> dual_res=0x7FFF_FFFF.
- max_iter=2, never converging, three passes -> max_iter_hit 0,1,1. clear_iter -> iter_count=0. start during busy -> ignored, exactly one done pulse.
- Assert rst during ISSUE -> all outputs 0 the next cycle, no done pulse. active_horizon=0 and active_horizon=40 -> processed as H=1 and H=30 (element count checked via rd_en cycle count).
